// File: rtl/image_conv_zero_sat.sv
// Zero-point add and requantisation clamp for the convolution output path.
// Two-stage valid/ready pipeline (add, clamp) with a saturating clamp-event counter.
module image_conv_zero_sat #(
    parameter int unsigned PICTURE_NUM     = 1,
    parameter int unsigned CHANNEL_OUT_NUM = 8,
    parameter int unsigned IN_W            = 16,
    parameter int unsigned OUT_W           = 8,
    parameter int unsigned ZP_W            = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [PICTURE_NUM*CHANNEL_OUT_NUM*IN_W-1:0]  shift_data_in,
    input  logic [ZP_W-1:0]                             zero_data_in,
    input  logic                                        mode_in,
    input  logic                                        valid_in,
    output logic                                        ready_in,
    output logic [PICTURE_NUM*CHANNEL_OUT_NUM*OUT_W-1:0] data_out,
    output logic                                        valid_out,
    input  logic                                        ready_out,
    input  logic                                        clr_cnt,
    output logic [CNT_W-1:0]                            sat_cnt
);

    localparam int unsigned N     = PICTURE_NUM * CHANNEL_OUT_NUM;
    localparam int unsigned SUM_W = IN_W + 1;

    localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'((2 ** OUT_W) - 1);
    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] S_MIN = ~S_MAX;

    logic                   en_c;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_mode_q,  s1_mode_d;
    logic [N*SUM_W-1:0]     s1_sum_q,   s1_sum_d;
    logic                   valid_out_q, valid_out_d;
    logic [N*OUT_W-1:0]     data_out_q,  data_out_d;
    logic                   s2_sat_q,    s2_sat_d;
    logic [CNT_W-1:0]       sat_cnt_q,   sat_cnt_d;

    logic [N*OUT_W-1:0]     clamp_data_c;
    logic                   clamp_sat_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [OUT_W-1:0]       lane_c;
    logic                   lane_sat_c;

    // Whole pipeline moves together unless the output register is full and blocked.
    assign en_c     = !valid_out_q || ready_out;
    assign ready_in = en_c;

    always_comb begin : s1_comb
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_sum_d   = s1_sum_q;
        if (en_c) begin
            s1_valid_d = valid_in;
            if (valid_in) begin
                s1_mode_d = mode_in;
                for (int unsigned l = 0; l < N; l++) begin
                    s1_sum_d[l*SUM_W +: SUM_W] =
                        {shift_data_in[l*IN_W+IN_W-1], shift_data_in[l*IN_W +: IN_W]} +
                        {{(SUM_W-ZP_W){1'b0}}, zero_data_in};
                end
            end
        end
    end

    always_comb begin : clamp_comb
        clamp_data_c = '0;
        clamp_sat_c  = 1'b0;
        sum_c        = '0;
        lane_c       = '0;
        lane_sat_c   = 1'b0;
        for (int unsigned l = 0; l < N; l++) begin
            sum_c      = s1_sum_q[l*SUM_W +: SUM_W];
            lane_c     = sum_c[OUT_W-1:0];
            lane_sat_c = 1'b0;
            if (!s1_mode_q) begin
                if (sum_c[SUM_W-1]) begin
                    lane_c     = '0;
                    lane_sat_c = 1'b1;
                end else if (sum_c > U_MAX) begin
                    lane_c     = '1;
                    lane_sat_c = 1'b1;
                end
            end else begin
                if (sum_c < S_MIN) begin
                    lane_c     = {1'b1, {(OUT_W-1){1'b0}}};
                    lane_sat_c = 1'b1;
                end else if (sum_c > S_MAX) begin
                    lane_c     = {1'b0, {(OUT_W-1){1'b1}}};
                    lane_sat_c = 1'b1;
                end
            end
            clamp_data_c[l*OUT_W +: OUT_W] = lane_c;
            clamp_sat_c = clamp_sat_c | lane_sat_c;
        end
    end

    always_comb begin : s2_comb
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        s2_sat_d    = s2_sat_q;
        if (en_c) begin
            valid_out_d = s1_valid_q;
            if (s1_valid_q) begin
                data_out_d = clamp_data_c;
                s2_sat_d   = clamp_sat_c;
            end
        end
    end

    // Clear has priority over a same-cycle increment; counter sticks at all ones.
    always_comb begin : cnt_comb
        sat_cnt_d = sat_cnt_q;
        if (clr_cnt) begin
            sat_cnt_d = '0;
        end else if (valid_out_q && ready_out && s2_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_sum_q    <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            s2_sat_q    <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_sum_q    <= s1_sum_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            s2_sat_q    <= s2_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_image_conv_zero_sat.sv
// Self-checking bench for image_conv_zero_sat: table vectors, back-pressure,
// random traffic against an arithmetic reference, counter and reset corners.
module tb_image_conv_zero_sat;

    localparam int unsigned N     = 8;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned ZP_W  = 8;

    logic                 clk;
    logic                 rst_n;
    logic [N*IN_W-1:0]    shift_data_in;
    logic [ZP_W-1:0]      zero_data_in;
    logic                 mode_in;
    logic                 valid_in;
    logic                 ready_in;
    logic [N*OUT_W-1:0]   data_out;
    logic                 valid_out;
    logic                 ready_out;
    logic                 clr_cnt;
    logic [15:0]          sat_cnt;
    logic                 ready_in2;
    logic [N*OUT_W-1:0]   data_out2;
    logic                 valid_out2;
    logic [1:0]           sat_cnt2;

    image_conv_zero_sat #(.PICTURE_NUM(1), .CHANNEL_OUT_NUM(8), .IN_W(16), .OUT_W(8),
                          .ZP_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .shift_data_in(shift_data_in), .zero_data_in(zero_data_in),
        .mode_in(mode_in), .valid_in(valid_in), .ready_in(ready_in), .data_out(data_out),
        .valid_out(valid_out), .ready_out(ready_out), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt));

    image_conv_zero_sat #(.PICTURE_NUM(1), .CHANNEL_OUT_NUM(8), .IN_W(16), .OUT_W(8),
                          .ZP_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .shift_data_in(shift_data_in), .zero_data_in(zero_data_in),
        .mode_in(mode_in), .valid_in(valid_in), .ready_in(ready_in2), .data_out(data_out2),
        .valid_out(valid_out2), .ready_out(ready_out), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        sat;
        int          acc;
        int          st;
    } exp_t;

    typedef struct {
        int in_v [8];
        int zp;
        bit mode;
        int exp_v [8];
        bit exp_sat;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          cnt1 = 0;
    int          cnt2 = 0;
    int          rdy_mode = 0;
    int          bp_start = 0;
    logic        ro_force = 1'b1;
    logic        accepted;
    logic [63:0] pend_data;
    logic        pend_sat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: widen to int, add, clamp to the mode's range.
    task automatic model(input logic [127:0] din, input logic [7:0] zp, input logic mode,
                         output logic [63:0] dout, output logic sat);
        int v, lo, hi;
        dout = '0;
        sat  = 1'b0;
        lo = mode ? -128 : 0;
        hi = mode ? 127 : 255;
        for (int l = 0; l < 8; l++) begin
            v = int'($signed(din[l*16 +: 16])) + int'(zp);
            if (v < lo) begin v = lo; sat = 1'b1; end
            if (v > hi) begin v = hi; sat = 1'b1; end
            dout[l*8 +: 8] = 8'(v);
        end
    endtask

    // One clock: set ready_out, observe at negedge, advance to just after posedge.
    task automatic cycle();
        logic exp_v, deliver;
        exp_t e;
        case (rdy_mode)
            0: ready_out = 1'b1;
            1: ready_out = ($urandom % 4) != 0;
            2: ready_out = !(((cyc - bp_start) >= 3) && ((cyc - bp_start) <= 6));
            default: ready_out = ro_force;
        endcase
        @(negedge clk);
        exp_v = 1'b0;
        if (q.size() > 0) exp_v = (cyc - q[0].acc - (stalls - q[0].st)) >= 2;
        chk("valid_out", 64'(valid_out), 64'(exp_v));
        chk("ready_in", 64'(ready_in), 64'(!exp_v || ready_out));
        chk("sat_cnt", 64'(sat_cnt), 64'(cnt1));
        chk("sat_cnt_w2", 64'(sat_cnt2), 64'(cnt2));
        deliver = exp_v && ready_out;
        e.sat = 1'b0;
        if (deliver) begin
            e = q.pop_front();
            chk("data_out", data_out, e.data);
        end
        if (valid_in && (!exp_v || ready_out)) begin
            q.push_back('{data: pend_data, sat: pend_sat, acc: cyc, st: stalls});
            accepted = 1'b1;
        end
        if (exp_v && !ready_out) stalls++;
        if (clr_cnt) begin
            cnt1 = 0;
            cnt2 = 0;
        end else if (deliver && e.sat) begin
            cnt1 = (cnt1 < 65535) ? cnt1 + 1 : 65535;
            cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [127:0] din, input logic [7:0] zp, input logic mode,
                        input logic [63:0] ed, input logic es);
        valid_in      = 1'b1;
        shift_data_in = din;
        zero_data_in  = zp;
        mode_in       = mode;
        pend_data     = ed;
        pend_sat      = es;
        accepted      = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) cycle();
        if (!accepted) chk("accept_timeout", 64'(0), 64'(1));
        valid_in = 1'b0;
    endtask

    task automatic send_model(input logic [127:0] din, input logic [7:0] zp, input logic mode);
        logic [63:0] ed;
        logic        es;
        model(din, zp, mode, ed, es);
        send(din, zp, mode, ed, es);
    endtask

    task automatic drain();
        rdy_mode = 0;
        for (int k = 0; k < 60 && q.size() > 0; k++) cycle();
        if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    function automatic logic [127:0] rand_lanes();
        logic [127:0] d;
        for (int l = 0; l < 8; l++) begin
            if ($urandom % 4 == 0) d[l*16 +: 16] = 16'($urandom);
            else d[l*16 +: 16] = 16'(int'($urandom_range(0, 700)) - 350);
        end
        return d;
    endfunction

    initial begin
        logic [127:0] din;
        logic [63:0]  ed;

        tbl[0].in_v = '{-20, 100, 250, 32767, 0, -10, 245, 246};
        tbl[0].zp = 10;  tbl[0].mode = 1'b0;
        tbl[0].exp_v = '{0, 110, 255, 255, 10, 0, 255, 255};          tbl[0].exp_sat = 1'b1;
        tbl[1].in_v = '{-200, -128, 127, 300, 0, -1, 128, -129};
        tbl[1].zp = 0;   tbl[1].mode = 1'b1;
        tbl[1].exp_v = '{'h80, 'h80, 'h7F, 'h7F, 0, 'hFF, 'h7F, 'h80}; tbl[1].exp_sat = 1'b1;
        tbl[2].in_v = '{-3, -3, -3, -3, -3, -3, -3, -3};
        tbl[2].zp = 5;   tbl[2].mode = 1'b0;
        tbl[2].exp_v = '{2, 2, 2, 2, 2, 2, 2, 2};                      tbl[2].exp_sat = 1'b0;
        tbl[3].in_v = '{-3, -3, -3, -3, -3, -3, -3, -3};
        tbl[3].zp = 0;   tbl[3].mode = 1'b1;
        tbl[3].exp_v = '{'hFD, 'hFD, 'hFD, 'hFD, 'hFD, 'hFD, 'hFD, 'hFD}; tbl[3].exp_sat = 1'b0;
        tbl[4].in_v = '{-32768, 32767, -383, -384, -128, -127, -255, 0};
        tbl[4].zp = 255; tbl[4].mode = 1'b1;
        tbl[4].exp_v = '{'h80, 'h7F, 'h80, 'h80, 'h7F, 'h7F, 0, 'h7F}; tbl[4].exp_sat = 1'b1;
        tbl[5].in_v = '{0, 1, 255, 128, 7, 200, 254, 3};
        tbl[5].zp = 0;   tbl[5].mode = 1'b0;
        tbl[5].exp_v = '{0, 1, 255, 128, 7, 200, 254, 3};              tbl[5].exp_sat = 1'b0;

        rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1; clr_cnt = 1'b0;
        shift_data_in = '0; zero_data_in = '0; mode_in = 1'b0;
        pend_data = '0; pend_sat = 1'b0; accepted = 1'b0;
        #3;
        chk("rst_valid_out", 64'(valid_out), 64'(0));
        chk("rst_data_out", data_out, 64'(0));
        chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
        chk("rst_ready_in", 64'(ready_in), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors streamed back to back.
        rdy_mode = 0;
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < 8; l++) begin
                din[l*16 +: 16] = 16'(tbl[k].in_v[l]);
                ed[l*8 +: 8]    = 8'(tbl[k].exp_v[l]);
            end
            send(din, 8'(tbl[k].zp), tbl[k].mode, ed, tbl[k].exp_sat);
        end
        drain();

        // Eight beats with the sink stalled for four cycles.
        bp_start = cyc;
        rdy_mode = 2;
        for (int k = 0; k < 8; k++) send_model(rand_lanes(), 8'($urandom), 1'($urandom));
        drain();

        // Random traffic with random gaps and sink stalls.
        rdy_mode = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom % 3 == 0) begin
                zero_data_in  = 8'($urandom);
                mode_in       = 1'($urandom);
                shift_data_in = rand_lanes();
                cycle();
            end
            send_model(rand_lanes(), 8'($urandom), 1'($urandom));
        end
        drain();

        // Counter saturation on the narrow instance.
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        din = {8{16'sh7FFF}};
        for (int k = 0; k < 5; k++) send_model(din, 8'd0, 1'b0);
        drain();
        chk("cnt_w2_sticks", 64'(sat_cnt2), 64'(3));
        chk("cnt_five", 64'(sat_cnt), 64'(5));

        // Clear coincides with a saturating delivery.
        rdy_mode = 3;
        ro_force = 1'b0;
        send_model(din, 8'd0, 1'b0);
        cycle();
        cycle();
        clr_cnt  = 1'b1;
        ro_force = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        cycle();
        chk("clr_wins", 64'(sat_cnt), 64'(0));
        chk("clr_wins_w2", 64'(sat_cnt2), 64'(0));

        // Asynchronous reset with two beats in flight.
        rdy_mode = 0;
        send_model(din, 8'd3, 1'b0);
        send_model(rand_lanes(), 8'd1, 1'b1);
        chk("pre_rst_valid", 64'(valid_out), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out", 64'(valid_out), 64'(0));
        chk("mid_rst_data_out", data_out, 64'(0));
        chk("mid_rst_sat_cnt", 64'(sat_cnt), 64'(0));
        q.delete();
        cnt1 = 0;
        cnt2 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        send_model(rand_lanes(), 8'($urandom), 1'($urandom));
        drain();
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
